// File: rtl/slabboy_pkg.sv
// Shared types and helpers for the slabboy reset sequencer: FSM state encoding
// and a constant-friendly ceiling log2.
package slabboy_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        STABLE = 2'd1,
        SYS_UP = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Ceiling log2, never less than 1 so a counter built from it always has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/slabboy_sync.sv
// N-flop synchroniser for asynchronous single-bit inputs (PLL lock, buttons,
// UART RX). Synchronous active-low reset clears the whole chain.
module slabboy_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock) begin
        if (!resetn) chain <= '0;
        else         chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/slabboy_reset_seq.sv
// Staged reset generator: waits for a stable PLL lock, releases the system
// reset, then the CPU reset, and drops both on lock loss (counted, saturating).
module slabboy_reset_seq
    import slabboy_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CPU_DELAY_CYCLES   = 16,
    parameter int CNT_W              = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pll_locked,
    output logic             sys_resetn,
    output logic             cpu_resetn,
    output logic             ready,
    output logic [CNT_W-1:0] lock_lost_count,
    output logic [1:0]       state
);

    localparam int MAXC = (LOCK_STABLE_CYCLES > CPU_DELAY_CYCLES) ? LOCK_STABLE_CYCLES
                                                                  : CPU_DELAY_CYCLES;
    localparam int CW = clog2(MAXC);
    localparam logic [CW-1:0]    STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    CPU_LAST    = CW'(CPU_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_MAX    = {CNT_W{1'b1}};

    logic          lock_s;
    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lost;

    slabboy_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (pll_locked),
        .dout   (lock_s)
    );

    // Lock loss takes priority over reaching a terminal count.
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        lost    = 1'b0;
        case (cur)
            HOLD: begin
                cnt_nxt = '0;
                if (lock_s) nxt = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    nxt     = HOLD;
                    cnt_nxt = '0;
                end else if (cnt == STABLE_LAST) begin
                    nxt     = SYS_UP;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SYS_UP: begin
                if (!lock_s) begin
                    nxt     = HOLD;
                    cnt_nxt = '0;
                    lost    = 1'b1;
                end else if (cnt == CPU_LAST) begin
                    nxt     = RUN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    nxt  = HOLD;
                    lost = 1'b1;
                end
            end
            default: begin
                nxt     = HOLD;
                cnt_nxt = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur             <= HOLD;
            cnt             <= '0;
            sys_resetn      <= 1'b0;
            cpu_resetn      <= 1'b0;
            ready           <= 1'b0;
            lock_lost_count <= '0;
        end else begin
            cur        <= nxt;
            cnt        <= cnt_nxt;
            sys_resetn <= (nxt == SYS_UP) || (nxt == RUN);
            cpu_resetn <= (nxt == RUN);
            ready      <= (nxt == RUN);
            if (lost && lock_lost_count != LOST_MAX)
                lock_lost_count <= lock_lost_count + CNT_W'(1);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_slabboy_reset_seq.sv
// Directed bench for slabboy_reset_seq with SYNC=2, LOCK=8, CPU=4, CNT_W=2.
module tb_slabboy_reset_seq;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sys_resetn, cpu_resetn, ready;
    logic [1:0] lock_lost_count;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    slabboy_reset_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .CPU_DELAY_CYCLES   (4),
        .CNT_W              (2)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .pll_locked      (pll_locked),
        .sys_resetn      (sys_resetn),
        .cpu_resetn      (cpu_resetn),
        .ready           (ready),
        .lock_lost_count (lock_lost_count),
        .state           (state)
    );

    always #5 clock = ~clock;

    // Advance one active edge, then sit 1 time unit past it.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Expected {state, sys_resetn, cpu_resetn, ready} r edges after lock is first sampled.
    function automatic logic [4:0] exp_seq(input int r);
        logic [1:0] s;
        s = (r < 2) ? 2'd0 : (r < 10) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
        return {s, r >= 10, r >= 14, r >= 14};
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        pll_locked = 1'b0;
        step(1);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        pll_locked = 1'b0;
        step(3);
        n_cmp++; if (sys_resetn !== 1'b0) begin n_bad++; $display("FAIL reset_sys got %b want 0", sys_resetn); end
        n_cmp++; if (cpu_resetn !== 1'b0) begin n_bad++; $display("FAIL reset_cpu got %b want 0", cpu_resetn); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (lock_lost_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", lock_lost_count); end
    endtask

    // Continues from test_reset at edge 3; lock first sampled at edge 10.
    task automatic test_powerup();
        logic [4:0] got;
        resetn = 1'b1;
        step(6);
        pll_locked = 1'b1;
        for (int r = 0; r < 16; r++) begin
            step(1);
            got = {state, sys_resetn, cpu_resetn, ready};
            n_cmp++;
            if (got !== exp_seq(r)) begin
                n_bad++;
                $display("FAIL powerup edge=%0d got %b want %b", r + 10, got, exp_seq(r));
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        pll_locked = 1'b1;
        for (int r = 0; r < 13; r++) begin
            if (r == 5) pll_locked = 1'b0;
            step(1);
            n_cmp++;
            if (sys_resetn !== 1'b0 || cpu_resetn !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_resets r=%0d got sys=%b cpu=%b want 0", r, sys_resetn, cpu_resetn);
            end
        end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL glitch_state got %0d want 0", state); end
        n_cmp++; if (lock_lost_count !== 2'd0) begin n_bad++; $display("FAIL glitch_count got %0d want 0", lock_lost_count); end
    endtask

    task automatic test_loss_run();
        logic [4:0] got;
        do_reset();
        pll_locked = 1'b1;
        step(15);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL lossrun_pre got %0d want 3", state); end
        pll_locked = 1'b0;
        step(2);
        n_cmp++;
        if ({state, sys_resetn, cpu_resetn, ready} !== 5'b11111) begin
            n_bad++;
            $display("FAIL lossrun_hold got %b want 11111", {state, sys_resetn, cpu_resetn, ready});
        end
        step(1);
        n_cmp++;
        if ({state, sys_resetn, cpu_resetn, ready} !== 5'b00000) begin
            n_bad++;
            $display("FAIL lossrun_drop got %b want 00000", {state, sys_resetn, cpu_resetn, ready});
        end
        n_cmp++; if (lock_lost_count !== 2'd1) begin n_bad++; $display("FAIL lossrun_count got %0d want 1", lock_lost_count); end
        step(3);
        pll_locked = 1'b1;
        for (int r = 0; r < 16; r++) begin
            step(1);
            got = {state, sys_resetn, cpu_resetn, ready};
            n_cmp++;
            if (got !== exp_seq(r)) begin
                n_bad++;
                $display("FAIL lossrun_reseq r=%0d got %b want %b", r, got, exp_seq(r));
            end
        end
    endtask

    task automatic test_loss_sysup();
        do_reset();
        pll_locked = 1'b1;
        for (int r = 0; r < 18; r++) begin
            if (r == 12) pll_locked = 1'b0;
            step(1);
            n_cmp++;
            if (cpu_resetn !== 1'b0) begin n_bad++; $display("FAIL sysup_cpu r=%0d got %b want 0", r, cpu_resetn); end
            if (r == 13) begin
                n_cmp++;
                if (sys_resetn !== 1'b1 || state !== 2'd2) begin
                    n_bad++;
                    $display("FAIL sysup_pre got sys=%b state=%0d want 1/2", sys_resetn, state);
                end
            end
        end
        n_cmp++; if (sys_resetn !== 1'b0) begin n_bad++; $display("FAIL sysup_sys got %b want 0", sys_resetn); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL sysup_state got %0d want 0", state); end
        n_cmp++; if (lock_lost_count !== 2'd1) begin n_bad++; $display("FAIL sysup_count got %0d want 1", lock_lost_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] want [5];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b1;
            step(15);
            n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL sat_run i=%0d got %0d want 3", i, state); end
            pll_locked = 1'b0;
            step(3);
            n_cmp++;
            if (lock_lost_count !== want[i]) begin
                n_bad++;
                $display("FAIL sat_count i=%0d got %0d want %0d", i, lock_lost_count, want[i]);
            end
        end
    endtask

    // Runs after saturation so the count is nonzero going in.
    task automatic test_reset_mid();
        logic [4:0] got;
        pll_locked = 1'b1;
        step(15);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL mid_pre got %0d want 3", state); end
        resetn = 1'b0;
        step(1);
        n_cmp++;
        if ({state, sys_resetn, cpu_resetn, ready} !== 5'b00000 || lock_lost_count !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_abort got %b cnt=%0d want 00000 cnt=0",
                     {state, sys_resetn, cpu_resetn, ready}, lock_lost_count);
        end
        resetn = 1'b1;
        for (int r = 0; r < 16; r++) begin
            step(1);
            got = {state, sys_resetn, cpu_resetn, ready};
            n_cmp++;
            if (got !== exp_seq(r)) begin
                n_bad++;
                $display("FAIL mid_reseq r=%0d got %b want %b", r, got, exp_seq(r));
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_glitch();
        test_loss_run();
        test_loss_sysup();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slabboy_reset_seq.md
Name: slabboy_reset_seq

Overview:
- Consumes the PLL `locked` flag on the 16 MHz PLL output clock and produces clean, staged active-low resets for the rest of the design.
- Holds the system in reset until lock has been stable for a programmable time.
- Releases the system (video/memory) reset first, then the CPU reset.
- Forces everything back into reset on loss of lock, and counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2, flops in the `pll_locked` synchroniser chain (min 2).
- LOCK_STABLE_CYCLES, 1024, cycles synchronised lock must stay high before the system reset is released (min 1).
- CPU_DELAY_CYCLES, 16, cycles between system-reset release and CPU-reset release (min 1).
- CNT_W, 8, width of the lock-loss counter.

Ports:
- clock  input  1  16 MHz PLL output clock; the only clock.
- resetn  input  1  synchronous, active-low reset (external button / power-on).
- pll_locked  input  1  PLL lock flag, asynchronous to `clock`.
- sys_resetn  output  1  active-low reset for system logic; registered.
- cpu_resetn  output  1  active-low reset for the CPU; registered.
- ready  output  1  high in RUN state; registered.
- lock_lost_count  output  CNT_W  saturating count of lock losses; registered.
- state  output  2  current FSM state, for debug.

Behaviour:
- One clock, `clock`. Reset is synchronous and active-low (`resetn`).
- `resetn`=0 at an edge forces the following, overriding all other events:
  - state=HOLD, all counters=0, synchroniser flops=0.
  - sys_resetn=0, cpu_resetn=0, ready=0, lock_lost_count=0.
- `resetn`=0 mid-sequence aborts immediately with the same result.
- Synchroniser: `pll_locked` passes through SYNC_STAGES flops; the last stage is `lock_s`. No logic reads `pll_locked` directly.
- State encoding: HOLD=0, STABLE=1, SYS_UP=2, RUN=3.
- HOLD:
  - Outputs low; `cnt` held at 0.
  - If lock_s=1 → STABLE with cnt=0.
- STABLE:
  - If lock_s=0 → HOLD. This is not counted as a loss.
  - Else if cnt==LOCK_STABLE_CYCLES-1 → SYS_UP, cnt=0, and sys_resetn goes 1 on the same edge.
  - Else cnt+1.
- SYS_UP:
  - If lock_s=0 → HOLD, lock_lost_count+1, sys_resetn=0 on the same edge.
  - Else if cnt==CPU_DELAY_CYCLES-1 → RUN, and cpu_resetn=1, ready=1 on the same edge.
  - Else cnt+1.
- RUN:
  - If lock_s=0 → HOLD, lock_lost_count+1.
  - sys_resetn, cpu_resetn and ready all go 0 on the same edge.
- Latency:
  - If `pll_locked`=1 is first sampled at edge k, sys_resetn rises at edge k+SYNC_STAGES+LOCK_STABLE_CYCLES.
  - cpu_resetn rises CPU_DELAY_CYCLES edges after that.
- Loss latency: if `pll_locked`=0 is first sampled at edge j, the outputs drop at edge j+SYNC_STAGES.
- Glitch rule: a lock pulse shorter than the stable window never releases any reset.
- lock_lost_count saturates at 2^CNT_W-1 and never wraps.
- `cnt` width is clog2 of the maximum of the two cycle parameters. The counter never exceeds its terminal value.
- Invariants:
  - cpu_resetn=1 implies sys_resetn=1.
  - ready == cpu_resetn.
  - No output ever changes combinationally.

Decomposition:
- Shared package `slabboy_pkg`: state typedef/localparams (HOLD/STABLE/SYS_UP/RUN) and the `clog2` helper.
- One natural sub-module: `slabboy_sync`, a parameterised N-flop synchroniser with synchronous active-low reset. It is reused for other asynchronous inputs (buttons, UART RX).

Test Plan:
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, CPU_DELAY_CYCLES=4, CNT_W=2 unless stated.
- Power-up: resetn low for 3 cycles, then pll_locked=1 first sampled at edge 10 → sys_resetn rises at edge 20, cpu_resetn/ready at edge 24, state=3.
- Lock glitch: pll_locked high for 5 cycles, then low → sys_resetn stays 0 throughout, state returns to 0, lock_lost_count=0.
- Loss in RUN: from RUN, drop pll_locked sampled at edge j → all outputs 0 at edge j+2, lock_lost_count=1. Restore lock → full re-sequence with the same 10/4-cycle delays.
- Loss in SYS_UP: drop lock 2 cycles after sys_resetn rise → cpu_resetn never rises, sys_resetn falls, lock_lost_count increments.
- Saturation: cause 5 losses with CNT_W=2 → lock_lost_count reads 1,2,3,3,3.
- Reset mid-operation: assert resetn=0 for 1 cycle in RUN with lock held → next edge all outputs 0, count=0. Re-sequence completes 10+4 cycles after release.
